vgg_class_argmax: RTL

Output-side classifier stage downstream of `vip_top`. It drains the network's output FIFO one 32-bit IEEE-754 score per cycle. It tracks the running maximum per image and delimits images by the FIFO's tag bit (`image_class`, set on the last score of an image). It presents `{class index, max score}` on a valid/ready result port and raises `done` after `NUM_IMG` images. It replaces `tb_writer` as the consumer in system builds.

---
 rtl/vgg_class_argmax_pkg.sv | 20 ++
 rtl/vgg_class_argmax_if.sv | 26 ++
 rtl/vgg_class_argmax_fp32_key_cmp.sv | 19 +
 rtl/vgg_class_argmax.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/vgg_class_argmax_pkg.sv
// Shared types, default dimensions and the fp32 ordering-key helper for the classifier stage.
package vgg_class_argmax_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_NUM_CLASS  = 1000;
  localparam int DEF_IDX_WIDTH  = 10;
  localparam int DEF_NUM_IMG    = 1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Maps an fp32 bit pattern onto an unsigned key whose order matches the float order.
  function automatic logic [31:0] fp32_key(input logic [31:0] x);
    return x[31] ? ~x : (x ^ 32'h8000_0000);
  endfunction

endpackage

// File: rtl/vgg_class_argmax_if.sv
// Output-FIFO read port plus valid/ready result port of the classifier stage.
interface vgg_class_argmax_if #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH  = 10
);
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_last;
  logic                  fifo_empty;
  logic                  fifo_rdreq;
  logic                  result_valid;
  logic                  result_ready;
  logic [IDX_WIDTH-1:0]  result_class;
  logic [DATA_WIDTH-1:0] result_score;
  logic                  result_err;
  logic                  done;

  modport master (
    input  fifo_data, fifo_last, fifo_empty, result_ready,
    output fifo_rdreq, result_valid, result_class, result_score, result_err, done
  );

  modport slave (
    output fifo_data, fifo_last, fifo_empty, result_ready,
    input  fifo_rdreq, result_valid, result_class, result_score, result_err, done
  );
endinterface

// File: rtl/vgg_class_argmax_fp32_key_cmp.sv
// Combinational greater-than between two fp32 values via their ordering keys.
module fp32_key_cmp
  import vgg_class_argmax_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        gt
);

  logic [31:0] a_key;
  logic [31:0] b_key;

  always_comb begin
    a_key = fp32_key(a);
    b_key = fp32_key(b);
    gt    = a_key > b_key;
  end

endmodule

// File: rtl/vgg_class_argmax.sv
// Argmax over per-image fp32 scores drained from the network output FIFO.
// Optional score-count checking is enabled by defining ARGMAX_CNT_CHECK_EN.
module vgg_class_argmax
  import vgg_class_argmax_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NUM_CLASS  = DEF_NUM_CLASS,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
  parameter int NUM_IMG    = DEF_NUM_IMG
) (
  input logic               clk,
  input logic               reset,
  vgg_class_argmax_if.master bus
);

  localparam int IMG_W = $clog2(NUM_IMG + 1);

  state_t                state_reg;
  logic                  rd_d1_reg;
  logic                  skid_full_reg;
  logic                  skid_last_reg;
  logic [DATA_WIDTH-1:0] skid_data_reg;
  logic                  first_reg;
  logic [IDX_WIDTH-1:0]  idx_reg;
  logic [IDX_WIDTH-1:0]  best_idx_reg;
  logic [DATA_WIDTH-1:0] best_score_reg;
  logic [IMG_W-1:0]      img_cnt_reg;
  logic                  result_valid_reg;
  logic [IDX_WIDTH-1:0]  result_class_reg;
  logic [DATA_WIDTH-1:0] result_score_reg;
  logic                  done_reg;

  logic                  rdreq;
  logic                  word_valid;
  logic [DATA_WIDTH-1:0] word_data;
  logic                  word_last;
  logic                  word_gt;
  logic                  take;
  logic [IDX_WIDTH-1:0]  sel_idx;
  logic [DATA_WIDTH-1:0] sel_score;
  logic [IDX_WIDTH-1:0]  idx_inc;
  logic                  hs;

  // A parked over-read word always takes priority; reads stay blocked until it is consumed.
  always_comb begin
    rdreq      = (state_reg == ST_RUN) && !bus.fifo_empty && !skid_full_reg && !reset;
    word_valid = (state_reg == ST_RUN) && (skid_full_reg || rd_d1_reg);
    word_data  = skid_full_reg ? skid_data_reg : bus.fifo_data;
    word_last  = skid_full_reg ? skid_last_reg : bus.fifo_last;
    take       = first_reg || word_gt;
    sel_idx    = take ? idx_reg : best_idx_reg;
    sel_score  = take ? word_data : best_score_reg;
    idx_inc    = (idx_reg == {IDX_WIDTH{1'b1}}) ? idx_reg : idx_reg + 1'b1;
    hs         = result_valid_reg && bus.result_ready;
  end

  fp32_key_cmp u_cmp (
    .a  (word_data),
    .b  (best_score_reg),
    .gt (word_gt)
  );

`ifdef ARGMAX_CNT_CHECK_EN
  logic over_reg;
  logic result_err_reg;
  logic at_end;
  logic err_now;

  always_comb begin
    at_end  = (idx_reg == IDX_WIDTH'(NUM_CLASS - 1));
    err_now = over_reg || !at_end;
  end

  assign bus.result_err = result_err_reg;
`else
  assign bus.result_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= ST_RUN;
      rd_d1_reg        <= 1'b0;
      skid_full_reg    <= 1'b0;
      skid_last_reg    <= 1'b0;
      skid_data_reg    <= '0;
      first_reg        <= 1'b1;
      idx_reg          <= '0;
      best_idx_reg     <= '0;
      best_score_reg   <= '0;
      img_cnt_reg      <= '0;
      result_valid_reg <= 1'b0;
      result_class_reg <= '0;
      result_score_reg <= '0;
      done_reg         <= 1'b0;
`ifdef ARGMAX_CNT_CHECK_EN
      over_reg         <= 1'b0;
      result_err_reg   <= 1'b0;
`endif
    end else begin
      rd_d1_reg <= rdreq;
      case (state_reg)
        ST_RUN: begin
          if (word_valid) begin
            skid_full_reg <= 1'b0;
            if (word_last) begin
              result_valid_reg <= 1'b1;
              result_class_reg <= sel_idx;
              result_score_reg <= sel_score;
              first_reg        <= 1'b1;
              idx_reg          <= '0;
              best_idx_reg     <= '0;
              best_score_reg   <= '0;
              state_reg        <= ST_EMIT;
`ifdef ARGMAX_CNT_CHECK_EN
              result_err_reg   <= err_now;
              over_reg         <= 1'b0;
`endif
            end else begin
              first_reg      <= 1'b0;
              idx_reg        <= idx_inc;
              best_idx_reg   <= sel_idx;
              best_score_reg <= sel_score;
`ifdef ARGMAX_CNT_CHECK_EN
              // Passing the final index without a tag marks the image as mis-sized.
              if (at_end) over_reg <= 1'b1;
`endif
            end
          end
        end
        ST_EMIT: begin
          if (rd_d1_reg && !skid_full_reg) begin
            skid_full_reg <= 1'b1;
            skid_data_reg <= bus.fifo_data;
            skid_last_reg <= bus.fifo_last;
          end
          if (hs) begin
            result_valid_reg <= 1'b0;
            img_cnt_reg      <= img_cnt_reg + 1'b1;
            if (img_cnt_reg == IMG_W'(NUM_IMG - 1)) begin
              state_reg <= ST_DONE;
              done_reg  <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
            end
          end
        end
        ST_DONE: begin
          if (rd_d1_reg && !skid_full_reg) begin
            skid_full_reg <= 1'b1;
            skid_data_reg <= bus.fifo_data;
            skid_last_reg <= bus.fifo_last;
          end
        end
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  assign bus.fifo_rdreq   = rdreq;
  assign bus.result_valid = result_valid_reg;
  assign bus.result_class = result_class_reg;
  assign bus.result_score = result_score_reg;
  assign bus.done         = done_reg;

endmodule
